split_demux: RTL
================

// Module: split_demux
//
// PURPOSE
//  Registered 1-to-NUM_OUT demultiplexer; the distribution counterpart of the registered
//  4:1 select mux. It steers one valid/ready input stream to one of NUM_OUT output
//  channels chosen by a per-beat select.
//  - Each channel owns a one-entry output register with its own valid/ready handshake.
//  - A stalled channel blocks only beats addressed to it.
//  - Sits between a single producer and four independent consumers in the split datapath.
//
// PARAMETERS
//  WIDTH    8   data width per beat
//  NUM_OUT  4   number of output channels (2..4)
//  SEL_W    2   select width; must be >= $clog2(NUM_OUT)
//  CNT_W    16  width of the accepted-beat counter
//
// PORTS
//  clk_w        in   1              single clock, all state on posedge
//  rst_w        in   1              asynchronous, active-high reset
//  in_valid_w   in   1              input beat present
//  in_ready_w   out  1              input beat accepted this cycle when high with in_valid_w
//  in_data_w    in   WIDTH          input payload
//  in_sel_w     in   SEL_W          destination channel for the beat
//  out_valid_w  out  NUM_OUT        per-channel output valid, bit i = channel i
//  out_ready_w  in   NUM_OUT        per-channel consumer ready
//  out_data_w   out  NUM_OUT*WIDTH  channel i payload at [i*WIDTH +: WIDTH]
//  beat_cnt_w   out  CNT_W          count of accepted input beats
//
// BEHAVIOUR
//  - Reset: while rst_w is high, the following are cleared immediately (asynchronously)
//    and held at 0:
//      - out_valid_w
//      - out_data_w
//      - beat_cnt_w
//    Any in-flight beat is discarded. in_ready_w follows its formula below.
//  - Effective destination: dst = (in_sel_w < NUM_OUT) ? in_sel_w : NUM_OUT-1.
//    Out-of-range selects go to the last channel, like the default arm of the select mux.
//  - Readiness: in_ready_w = !out_valid_w[dst] | out_ready_w[dst].
//    - Combinational from in_sel_w and out_ready_w; never depends on in_valid_w.
//  - Accept: the input is accepted when in_valid_w && in_ready_w.
//    - At the next posedge: out_data_w[dst] <= in_data_w, out_valid_w[dst] <= 1,
//      beat_cnt_w <= beat_cnt_w + 1.
//    - beat_cnt_w wraps modulo 2**CNT_W with no saturation.
//    - Latency: input accept to out_valid_w high is exactly 1 cycle.
//  - Drain: channel i completes a transfer when out_valid_w[i] && out_ready_w[i].
//    - At the next posedge out_valid_w[i] <= 0, unless the same cycle also accepts a new
//      beat for i.
//  - Simultaneous drain and accept on the same channel: the new beat replaces the old one.
//    - out_valid_w[i] stays 1 and out_data_w[i] takes the new payload.
//    - Full throughput is 1 beat/clk per channel when its consumer holds ready high.
//  - Independence: beats to other channels are unaffected by a stalled channel j.
//    - Only a beat with dst == j sees in_ready_w = 0 while channel j is full and
//      out_ready_w[j] = 0.
//  - Stability: while out_valid_w[i] && !out_ready_w[i], out_data_w[i] and out_valid_w[i]
//    hold constant.
//  - Data value: out_data_w[i] keeps its last payload after draining. Only out_valid_w
//    qualifies the data.
//  - in_valid_w low: no state change except channel drains. in_data_w and in_sel_w are
//    don't-care.
//  - Per-channel FSM (2 states):
//      - EMPTY -> FULL  on accept to i.
//      - FULL  -> EMPTY on drain with no accept.
//      - FULL  -> FULL  on stall, or on drain+accept.
//  - Reset asserted mid-stream: all channels return to EMPTY asynchronously.
//    - The first beat after deassertion is accepted normally.
//
// TESTING
//  1. Reset: assert rst_w mid-cycle with channels full
//     -> out_valid_w=0, beat_cnt_w=0 before the next posedge; in_ready_w=1 for all selects.
//  2. Route: sel=0..3 with data A0,B1,C2,D3 on 4 consecutive cycles, all out_ready_w=1
//     -> each channel shows its byte 1 cycle later for 1 cycle; beat_cnt_w=4.
//  3. Stall isolation: out_ready_w=4'b1101 and a beat to channel 1 (0x55)
//     -> a 2nd beat to sel=1 sees in_ready_w=0 and ch1 holds 0x55.
//     -> a beat to sel=2 (0x66) is accepted in the same window.
//  4. Back-to-back: ch3 full and ready=1, new beat 0x99 to sel=3
//     -> accepted; out_valid_w[3] stays 1; data becomes 0x99 with no bubble.
//  5. Out-of-range: NUM_OUT=3, sel=2'b11, data 0x7E
//     -> delivered on channel 2; channels 0 and 1 untouched.
//  6. Counter wrap: CNT_W=4, 17 accepted beats
//     -> beat_cnt_w=1.

Source files
------------

// File: rtl/split_demux.sv
// split_demux: registered 1-to-NUM_OUT demultiplexer.
//
// Each beat on the input valid/ready stream goes to one output channel. The
// channel is picked by the per-beat select. Selects at or above NUM_OUT go to
// the last channel. Every channel has a one-entry output register with its own
// valid/ready handshake, so a stalled channel only blocks beats addressed to it.
//
// Handshake rule (input and every output channel): a beat moves on a posedge
// where valid && ready. valid never depends on ready. in_ready_w is
// combinational from in_sel_w and out_ready_w and never looks at in_valid_w.
// Once raised, out_valid_w[i] and out_data_w[i] hold until the consumer takes
// the beat.
//
// Ports:
//   clk_w        clock, all state on posedge
//   rst_w        asynchronous active-high reset
//   in_valid_w   input beat present
//   in_ready_w   input beat accepted when high together with in_valid_w
//   in_data_w    input payload (WIDTH)
//   in_sel_w     destination channel (SEL_W)
//   out_valid_w  per-channel output valid, bit i = channel i
//   out_ready_w  per-channel consumer ready
//   out_data_w   channel i payload at [i*WIDTH +: WIDTH]
//   beat_cnt_w   accepted-beat counter, wraps modulo 2**CNT_W
//
// Debug: each channel's EMPTY/FULL state is in g_ch[i].state_q.
module split_demux #(
  parameter int WIDTH   = 8,
  parameter int NUM_OUT = 4,
  parameter int SEL_W   = 2,
  parameter int CNT_W   = 16
) (
  input  logic                       clk_w,
  input  logic                       rst_w,
  input  logic                       in_valid_w,
  output logic                       in_ready_w,
  input  logic [WIDTH-1:0]           in_data_w,
  input  logic [SEL_W-1:0]           in_sel_w,
  output logic [NUM_OUT-1:0]         out_valid_w,
  input  logic [NUM_OUT-1:0]         out_ready_w,
  output logic [NUM_OUT*WIDTH-1:0]   out_data_w,
  output logic [CNT_W-1:0]           beat_cnt_w
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} ch_state_t;

  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_OUT - 1);

  logic [SEL_W-1:0]   dst;
  logic [NUM_OUT-1:0] dst_hot;
  logic [NUM_OUT-1:0] ch_open;
  logic               accept;

  // Out-of-range selects fall through to the last channel.
  assign dst = (in_sel_w > LAST_SEL) ? LAST_SEL : in_sel_w;

  // A channel can take a beat when it is empty, or when it drains this cycle.
  assign in_ready_w = |(dst_hot & ch_open);
  assign accept     = in_valid_w & in_ready_w;

  for (genvar i = 0; i < NUM_OUT; i++) begin : g_ch
    ch_state_t        state_q;
    ch_state_t        state_d;
    logic [WIDTH-1:0] data_q;
    logic             load;

    assign dst_hot[i] = (dst == SEL_W'(i));
    assign ch_open[i] = (state_q == EMPTY) | out_ready_w[i];
    assign load       = accept & dst_hot[i];

    always_ff @(posedge clk_w or posedge rst_w) begin
      if (rst_w) begin
        state_q <= EMPTY;
      end else begin
        state_q <= state_d;
      end
    end

    // If a drain and an accept happen in the same cycle, the channel stays FULL.
    // The new beat replaces the old one, so throughput is one beat per clock.
    always_comb begin
      state_d = state_q;
      case (state_q)
        EMPTY:   if (load) state_d = FULL;
        FULL:    if (out_ready_w[i] && !load) state_d = EMPTY;
        default: state_d = EMPTY;
      endcase
    end

    // The payload is kept after draining; only out_valid_w qualifies it.
    always_ff @(posedge clk_w or posedge rst_w) begin
      if (rst_w) begin
        data_q <= '0;
      end else if (load) begin
        data_q <= in_data_w;
      end
    end

    assign out_valid_w[i]                = (state_q == FULL);
    assign out_data_w[i*WIDTH +: WIDTH]  = data_q;
  end

  always_ff @(posedge clk_w or posedge rst_w) begin
    if (rst_w) begin
      beat_cnt_w <= '0;
    end else if (accept) begin
      beat_cnt_w <= beat_cnt_w + 1'b1;
    end
  end

endmodule
